// File: rtl/pwm_generator_mc.sv
// Multi-channel PWM generator.
// A free-running DW-bit counter sets the period (2^DW cycles). Each channel
// has a shadow duty register that software writes at any time and an
// active duty register that the comparator uses. Shadow values move to
// active only at the period boundary (or at once while stopped), so a
// duty change never produces a truncated or glitched pulse.
module pwm_generator_mc #(
  parameter int CH = 4,
  parameter int DW = 8,
  localparam int SW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          enable,
  input  logic [SW-1:0] ch_sel,
  input  logic [DW-1:0] data_in,
  output logic [CH-1:0] pwm,
  output logic [CH-1:0] valid,
  output logic [CH-1:0] pending,
  output logic          sync
);

  logic [DW-1:0]          cnt_q, cnt_d;
  logic [CH-1:0][DW-1:0]  shadow_q, shadow_d;
  logic [CH-1:0][DW-1:0]  active_q, active_d;
  logic [CH-1:0]          pending_q, pending_d;
  logic [CH-1:0]          valid_q, valid_d;
  logic [CH-1:0]          pwm_q, pwm_d;
  logic                   sync_q, sync_d;
  logic                   boundary;

  // Next-state logic: counter, shadow/active transfer, comparators, sync.
  always_comb begin
    // NOTE: every signal gets a default at the top so no path leaves it
    // unassigned; a missing default here would infer a latch.
    cnt_d     = run ? cnt_q + DW'(1) : '0;
    boundary  = run && (cnt_q == '1);
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    valid_d   = '0;
    pwm_d     = '0;
    sync_d    = run && (cnt_q == '0);

    for (int i = 0; i < CH; i++) begin
      // Transfer uses the pre-edge shadow value; happens at the period
      // boundary, or on the very next edge while the counter is stopped.
      if (pending_q[i] && (boundary || !run)) begin
        active_d[i]  = shadow_q[i];
        pending_d[i] = 1'b0;
        valid_d[i]   = 1'b1;
      end
      // A write on the same edge wins over the clear: the new value stays
      // pending for the following transfer. Out-of-range ch_sel matches
      // no channel and is dropped.
      if (enable && (ch_sel == SW'(i))) begin
        shadow_d[i]  = data_in;
        pending_d[i] = 1'b1;
      end
      // Compare against the active duty; output lands one cycle after cnt.
      pwm_d[i] = run && (cnt_q < active_q[i]);
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      // NOTE: the duty arrays are cleared on reset because a pending write
      // must not survive reset and the outputs must restart from duty 0.
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= '0;
      valid_q   <= '0;
      pwm_q     <= '0;
      sync_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      pwm_q     <= pwm_d;
      sync_q    <= sync_d;
    end
  end

  assign pwm     = pwm_q;
  assign valid   = valid_q;
  assign pending = pending_q;
  assign sync    = sync_q;

endmodule
